i2s_encoder: RTL and testbench

//  I2S master transmitter, upstream of the I2S receiver. Takes 16-bit stereo PCM samples

---
 rtl/i2s_pkg.sv | 19 +
 rtl/i2s_encoder_if.sv | 21 ++
 rtl/i2s_clkgen.sv | 47 ++++
 rtl/i2s_encoder.sv | 100 ++++++++++
 tb/tb_i2s_encoder.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2s_pkg.sv
// i2s_pkg: constants shared by the I2S encoder and the I2S decoder.
//   SAMPLE_W  PCM sample width
//   LR_LEFT / LR_RIGHT  word-select encoding (0 = left channel)
//   SLOT_MIN  smallest slot that fits one delay bit plus a full sample
package i2s_pkg;

    localparam int   SAMPLE_W = 16;
    localparam logic LR_LEFT  = 1'b0;
    localparam logic LR_RIGHT = 1'b1;
    localparam int   SLOT_MIN = SAMPLE_W + 1;

    typedef logic [SAMPLE_W-1:0] sample_t;

    // Bits needed for a counter running 0..count-1 (at least one bit).
    function automatic int cnt_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/i2s_encoder_if.sv
// i2s_encoder_if: PCM sample handshake plus I2S serial lines.
//   ldata, rdata  PCM sample pair offered by the mixer
//   next          one-clock strobe, sample pair has been taken
//   ck, lr, d     I2S bit clock, word select, serial data
// Modports:
//   master  the I2S transmitter (consumes samples, drives the serial lines)
//   slave   the mixer / serial receiver side
interface i2s_encoder_if;
    import i2s_pkg::*;

    sample_t ldata;
    sample_t rdata;
    logic    next;
    logic    ck;
    logic    lr;
    logic    d;

    modport master (input ldata, input rdata, output next, output ck, output lr, output d);
    modport slave  (output ldata, output rdata, input next, input ck, input lr, input d);

endinterface

// File: rtl/i2s_clkgen.sv
// i2s_clkgen: bit clock divider for the I2S transmitter.
// Parameters:
//   CLKDIV  system clocks per ck half-period (>= 1)
// Ports:
//   clock    system clock
//   reset    asynchronous reset, active low
//   ck       registered bit clock, 0 out of reset
//   ck_fall  high in the cycle whose closing edge takes ck 1->0
//   ck_rise  high in the cycle whose closing edge takes ck 0->1
module i2s_clkgen
    import i2s_pkg::*;
#(
    parameter int CLKDIV = 4
) (
    input  logic clock,
    input  logic reset,
    output logic ck,
    output logic ck_fall,
    output logic ck_rise
);

    localparam int              DIV_W    = cnt_width(CLKDIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKDIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             wrap;

    assign wrap = (div_cnt == DIV_LAST);

    // Strobes are combinational so that frame logic can act on the very edge
    // that toggles ck; with CLKDIV=1 wrap is permanently high.
    assign ck_fall = wrap & ck;
    assign ck_rise = wrap & ~ck;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
            ck      <= 1'b0;
        end else if (wrap) begin
            div_cnt <= '0;
            ck      <= ~ck;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/i2s_encoder.sv
// i2s_encoder: I2S master transmitter (Philips format, MSB first, one-bit
// delay after each lr edge, lr=0 left).
// Parameters:
//   CLKDIV     system clocks per ck half-period (>= 1)
//   SLOT_BITS  ck periods per channel slot (17..64)
// Ports:
//   clock  system clock
//   reset  asynchronous reset, active low
//   bus    i2s_encoder_if.master: ldata/rdata in, next/ck/lr/d out
//   mclk   codec master clock = clock/2, present only when I2S_MCLK_EN is defined
// Build option:
//   I2S_MCLK_EN  adds the mclk output and its toggle flop
module i2s_encoder
    import i2s_pkg::*;
#(
    parameter int CLKDIV    = 4,
    parameter int SLOT_BITS = 32
) (
    input  logic          clock,
    input  logic          reset,
    i2s_encoder_if.master bus
`ifdef I2S_MCLK_EN
   ,output logic          mclk
`endif
);

    localparam int             N_MAX  = 2 * SLOT_BITS;
    localparam int             N_W    = cnt_width(N_MAX);
    localparam logic [N_W-1:0] N_LAST = N_W'(N_MAX - 1);

    logic           ck_fall;
    logic [N_W-1:0] n;
    logic [N_W-1:0] n_nxt;
    logic           frame_start;
    logic           lr_nxt;
    logic           d_nxt;
    logic [3:0]     idx_l;
    logic [3:0]     idx_r;
    sample_t        shadow_l;
    sample_t        shadow_r;

    i2s_clkgen #(.CLKDIV(CLKDIV)) u_clkgen (
        .clock   (clock),
        .reset   (reset),
        .ck      (bus.ck),
        .ck_fall (ck_fall),
        .ck_rise ()
    );

    assign n_nxt       = (n == N_LAST) ? '0 : n + 1'b1;
    assign frame_start = ck_fall && (n_nxt == '0);
    assign lr_nxt      = (int'(n_nxt) >= SLOT_BITS) ? LR_RIGHT : LR_LEFT;
    assign idx_l       = 4'(SAMPLE_W - int'(n_nxt));
    assign idx_r       = 4'(SLOT_BITS + SAMPLE_W - int'(n_nxt));

    // Bit 0 of each slot is the I2S delay bit; bits past the sample are padding.
    always_comb begin
        d_nxt = 1'b0;
        if (int'(n_nxt) >= 1 && int'(n_nxt) <= SAMPLE_W) begin
            d_nxt = shadow_l[idx_l];
        end else if (int'(n_nxt) >= SLOT_BITS + 1 && int'(n_nxt) <= SLOT_BITS + SAMPLE_W) begin
            d_nxt = shadow_r[idx_r];
        end
    end

    // n starts at the last index so the first ck fall opens a frame with a
    // clean lr 1->0 edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            n        <= N_LAST;
            bus.lr   <= LR_RIGHT;
            bus.d    <= 1'b0;
            bus.next <= 1'b0;
            shadow_l <= '0;
            shadow_r <= '0;
        end else begin
            bus.next <= frame_start;
            if (frame_start) begin
                shadow_l <= bus.ldata;
                shadow_r <= bus.rdata;
            end
            if (ck_fall) begin
                n      <= n_nxt;
                bus.lr <= lr_nxt;
                bus.d  <= d_nxt;
            end
        end
    end

`ifdef I2S_MCLK_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mclk <= 1'b0;
        end else begin
            mclk <= ~mclk;
        end
    end
`endif

endmodule

// File: tb/tb_i2s_encoder.sv
`timescale 1ns/1ps
module tb_i2s_encoder;
    import i2s_pkg::*;

    localparam int DIV0   = 4;
    localparam int SLOT0  = 32;
    localparam int DIV1   = 1;
    localparam int SLOT1  = 17;
    localparam int FRAME0 = 2 * SLOT0 * 2 * DIV0;
    localparam int FRAME1 = 2 * SLOT1 * 2 * DIV1;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    i2s_encoder_if if0 ();
    i2s_encoder_if if1 ();

`ifdef I2S_MCLK_EN
    logic mclk0, mclk1;
`endif

    i2s_encoder #(.CLKDIV(DIV0), .SLOT_BITS(SLOT0)) dut0 (
        .clock (clock),
        .reset (reset),
        .bus   (if0)
`ifdef I2S_MCLK_EN
       ,.mclk  (mclk0)
`endif
    );

    i2s_encoder #(.CLKDIV(DIV1), .SLOT_BITS(SLOT1)) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (if1)
`ifdef I2S_MCLK_EN
       ,.mclk  (mclk1)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // scoreboard: expected sample per instance and channel
    logic [15:0] exp_l0[$], exp_r0[$], exp_l1[$], exp_r1[$];
    logic [15:0] cur_l[2], cur_r[2];
    int          stim_idx0;
    int          pend[2];
    int          last_next[2];
    int          cyc;
    int          fc0;
    logic        ckp0;

    // receiver model state
    int          rx_cnt[2];
    logic        rx_lr[2];
    logic [15:0] rx_sh[2];
    int          rx_pad[2];
    int          rx_words[2];

    function automatic logic [31:0] stim_pair0(input int idx);
        case (idx)
            0:       return {16'h8001, 16'h7FFE};
            1:       return {16'hA5C3, 16'h3C5A};
            2:       return {16'h1234, 16'h0F0F};
            3:       return {16'hFFFF, 16'hF00D};
            default: return $urandom;
        endcase
    endfunction

    task automatic present(input int i);
        logic [31:0] p;
        if (i == 0) begin
            p = stim_pair0(stim_idx0);
            stim_idx0++;
            cur_l[0] = p[31:16]; cur_r[0] = p[15:0];
            if0.ldata = cur_l[0]; if0.rdata = cur_r[0];
        end else begin
            p = $urandom;
            cur_l[1] = p[31:16]; cur_r[1] = p[15:0];
            if1.ldata = cur_l[1]; if1.rdata = cur_r[1];
        end
    endtask

    task automatic clear_all();
        exp_l0.delete(); exp_r0.delete(); exp_l1.delete(); exp_r1.delete();
        for (int i = 0; i < 2; i++) begin
            pend[i] = 0; last_next[i] = -1;
            rx_cnt[i] = -1; rx_lr[i] = LR_RIGHT; rx_sh[i] = '0; rx_pad[i] = 0; rx_words[i] = 0;
        end
        fc0 = 0;
        ckp0 = 1'b0;
    endtask

    task automatic word_done(input int i, input logic lr, input logic [15:0] w);
        logic [15:0] e;
        bit          have;
        have = 1'b0;
        e = '0;
        if (i == 0 && lr == LR_LEFT && exp_l0.size() > 0) begin e = exp_l0.pop_front(); have = 1'b1; end
        if (i == 0 && lr == LR_RIGHT && exp_r0.size() > 0) begin e = exp_r0.pop_front(); have = 1'b1; end
        if (i == 1 && lr == LR_LEFT && exp_l1.size() > 0) begin e = exp_l1.pop_front(); have = 1'b1; end
        if (i == 1 && lr == LR_RIGHT && exp_r1.size() > 0) begin e = exp_r1.pop_front(); have = 1'b1; end
        check($sformatf("sb_pending_u%0d_lr%0d", i, lr), 32'(have), 32'd1);
        if (have) check($sformatf("word_u%0d_lr%0d", i, lr), 32'(w), 32'(e));
        rx_words[i]++;
    endtask

    // I2S receiver: an lr change marks the delay bit, the next 16 rises carry MSB..LSB.
    task automatic rx_step(input int i, input int slot, input logic lr, input logic d);
        if (lr !== rx_lr[i]) begin
            if (rx_cnt[i] >= 0) begin
                check($sformatf("slot_len_u%0d", i), 32'(rx_cnt[i]), 32'(slot - 1));
                check($sformatf("pad_zero_u%0d", i), 32'(rx_pad[i]), 32'd0);
            end else begin
                check($sformatf("first_edge_left_u%0d", i), 32'(lr), 32'(LR_LEFT));
            end
            rx_lr[i]  = lr;
            rx_cnt[i] = 0;
            rx_sh[i]  = '0;
            rx_pad[i] = d ? 1 : 0;
        end else if (rx_cnt[i] >= 0) begin
            rx_cnt[i]++;
            if (rx_cnt[i] <= SAMPLE_W) rx_sh[i] = {rx_sh[i][14:0], d};
            else if (d) rx_pad[i]++;
            if (rx_cnt[i] == SAMPLE_W) word_done(i, lr, rx_sh[i]);
        end
    endtask

    always @(posedge if0.ck) rx_step(0, SLOT0, if0.lr, if0.d);
    always @(posedge if1.ck) rx_step(1, SLOT1, if1.lr, if1.d);

    always @(negedge reset) clear_all();

    // next-strobe monitor: pushes the pair the bench was presenting, checks
    // the frame period and schedules the next pair a few bit periods later
    always @(posedge clock) begin
        #1;
        cyc++;
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                if (pend[i] > 0) begin
                    pend[i]--;
                    if (pend[i] == 0) present(i);
                end
            end
            if (if0.ck === 1'b0 && ckp0 === 1'b1) fc0++;
            if (if0.next === 1'b1) begin
                exp_l0.push_back(cur_l[0]);
                exp_r0.push_back(cur_r[0]);
                fc0 = 0;
                if (last_next[0] >= 0) check("next_period_u0", 32'(cyc - last_next[0]), 32'(FRAME0));
                last_next[0] = cyc;
                pend[0] = 5 * 2 * DIV0;
            end
            if (if1.next === 1'b1) begin
                exp_l1.push_back(cur_l[1]);
                exp_r1.push_back(cur_r[1]);
                if (last_next[1] >= 0) check("next_period_u1", 32'(cyc - last_next[1]), 32'(FRAME1));
                last_next[1] = cyc;
                pend[1] = 5 * 2 * DIV1;
            end
            ckp0 = if0.ck;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int c;
        cyc = 0;
        stim_idx0 = 0;
        clear_all();
        present(0);
        present(1);

        repeat (3) @(posedge clock);
        #1;
        check("rst_ck_u0", 32'(if0.ck), 32'd0);
        check("rst_lr_u0", 32'(if0.lr), 32'd1);
        check("rst_d_u0", 32'(if0.d), 32'd0);
        check("rst_next_u0", 32'(if0.next), 32'd0);
        check("rst_lr_u1", 32'(if1.lr), 32'd1);
`ifdef I2S_MCLK_EN
        check("rst_mclk_u0", 32'(mclk0), 32'd0);
`endif

        @(negedge clock);
        reset = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clock);
            #2;
            if (k == 1) check("c1_ck_u1", 32'(if1.ck), 32'd1);
            if (k == 2) begin
                check("c2_ck_u1", 32'(if1.ck), 32'd0);
                check("c2_next_u1", 32'(if1.next), 32'd1);
                check("c2_lr_u1", 32'(if1.lr), 32'd0);
            end
            if (k == 3) begin
                check("c3_ck_u0", 32'(if0.ck), 32'd0);
                check("c3_next_u1", 32'(if1.next), 32'd0);
            end
            if (k == 4) check("c4_ck_u0", 32'(if0.ck), 32'd1);
            if (k == 7) begin
                check("c7_ck_u0", 32'(if0.ck), 32'd1);
                check("c7_next_u0", 32'(if0.next), 32'd0);
                check("c7_lr_u0", 32'(if0.lr), 32'd1);
            end
            if (k == 8) begin
                check("c8_ck_u0", 32'(if0.ck), 32'd0);
                check("c8_next_u0", 32'(if0.next), 32'd1);
                check("c8_lr_u0", 32'(if0.lr), 32'd0);
            end
            if (k == 9) check("c9_next_u0", 32'(if0.next), 32'd0);
        end

        // fixed patterns, loopback pair and the mid-frame ldata change
        for (c = 0; c < 6000 && rx_words[0] < 8; c++) @(posedge clock);
        check("words_phase1_u0", 32'(rx_words[0] >= 8), 32'd1);

        // reset at n=40 while ck is high
        seen = 1'b0;
        for (c = 0; c < 3000; c++) begin
            @(posedge clock);
            #2;
            if (if0.next === 1'b1) seen = 1'b1;
            if (seen && fc0 == 40) break;
        end
        check("reach_n40", 32'(seen && fc0 == 40), 32'd1);
        repeat (DIV0 + 1) @(posedge clock);
        #2;
        check("pre_reset_ck_high", 32'(if0.ck), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        check("midrst_ck_u0", 32'(if0.ck), 32'd0);
        check("midrst_lr_u0", 32'(if0.lr), 32'd1);
        check("midrst_d_u0", 32'(if0.d), 32'd0);
        check("midrst_next_u0", 32'(if0.next), 32'd0);
        check("midrst_ck_u1", 32'(if1.ck), 32'd0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;

        for (c = 0; c < 5000 && (rx_words[0] < 6 || rx_words[1] < 20); c++) @(posedge clock);
        check("words_phase2_u0", 32'(rx_words[0] >= 6), 32'd1);
        check("words_phase2_u1", 32'(rx_words[1] >= 20), 32'd1);

`ifdef I2S_MCLK_EN
        begin
            logic m_a;
            @(posedge clock);
            #2;
            m_a = mclk1;
            @(posedge clock);
            #2;
            check("mclk_toggle_u1", 32'(mclk1), 32'(~m_a));
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
